// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and default constants for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
  localparam int CLKS_PER_BIT_DEFAULT = 217;
  localparam int DATA_BITS_DEFAULT = 8;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-period counter producing mid-bit and full-bit ticks.
module uart_baud_counter import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  output logic mid_tick_o,
  output logic full_tick_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign mid_tick_o  = cnt_q == CW'(CLKS_PER_BIT / 2);
  assign full_tick_o = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign cnt_d = (clear_i || full_tick_o) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: UART frame receiver with ready/valid output, framing and overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit check and the parity_error port.
module uart_frame_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = DATA_BITS_DEFAULT,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 receiving
);
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic rx_prev_q, rxs, fall, mid_tick, full_tick, cnt_clear;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic bad_q, bad_d, ferr_q, ferr_d, valid_q, valid_d, ovr_q, ovr_d;
  logic done, hs, load, par_bad;
`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, perr_q, perr_d;
  assign par_bad = par_bad_q;
  assign parity_error = perr_q;
`else
  assign par_bad = 1'b0;
`endif
  assign rxs  = sync_q[1];
  assign fall = rx_prev_q & ~rxs;
  // Counter restarts at the start-bit centre so later samples land mid-bit.
  assign cnt_clear = (state_q == IDLE) || (state_q == BREAK) || (state_q == START && mid_tick);
  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (cnt_clear),
    .mid_tick_o (mid_tick),
    .full_tick_o(full_tick)
  );
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    bad_d     = bad_q;
    ferr_d    = ferr_q;
    done      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: if (fall) begin
        state_d   = START;
        bit_cnt_d = '0;
      end
      START: if (mid_tick) begin
        state_d = rxs ? IDLE : DATA;
        if (!rxs) begin
          ferr_d = 1'b0;
          bad_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      DATA: if (full_tick) begin
        shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
          bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (full_tick) begin
        par_bad_d = rxs ^ (^shift_q);
        state_d   = STOP;
      end
`endif
      STOP: if (full_tick) begin
        bad_d     = bad_q | ~rxs;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
          state_d = bad_d ? BREAK : IDLE;
          ferr_d  = ferr_q | bad_d;
          done    = ~bad_d & ~par_bad;
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad_q;
`endif
        end
      end
      BREAK: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign hs      = valid_q & data_ready;
  assign load    = done & (~valid_q | hs);
  assign data_d  = load ? shift_q : data_q;
  assign valid_d = load | (valid_q & ~hs);
  assign ovr_d   = hs ? 1'b0 : (ovr_q | (done & valid_q));
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      bad_q     <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rxs;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      bad_q     <= bad_d;
      ferr_q    <= ferr_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  assign data          = data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign overrun       = ovr_q;
  assign receiving     = state_q != IDLE;
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed bench for uart_frame_rx at 217 clocks per bit, 8N1.
module tb_uart_frame_rx;
  localparam int CPB = 217;
  logic clock = 1'b0, reset = 1'b0, rx = 1'b1, data_ready = 1'b1;
  logic [7:0] data, got = '0, fr;
  logic data_valid, framing_error, overrun, receiving;
  int vcount = 0, n_cmp = 0, n_bad = 0, v0;
`ifdef UART_RX_PARITY_EN
  logic parity_error;
  int pcount = 0, p0;
`endif
  always #5 clock = ~clock;
  uart_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
`ifdef UART_RX_PARITY_EN
    .parity_error (parity_error),
`endif
    .framing_error(framing_error),
    .overrun      (overrun),
    .receiving    (receiving)
  );
  always @(negedge clock) begin
    if (data_valid) begin
      vcount <= vcount + 1;
      got    <= data;
    end
`ifdef UART_RX_PARITY_EN
    if (parity_error) pcount <= pcount + 1;
`endif
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic bitp(input logic v);
    rx = v;
    repeat (CPB) @(negedge clock);
  endtask
  task automatic tx_frame(input logic [7:0] b);
    bitp(1'b0);
    for (int i = 0; i < 8; i++) bitp(b[i]);
`ifdef UART_RX_PARITY_EN
    bitp(^b);
`endif
    bitp(1'b1);
  endtask
  initial begin
    repeat (3) @(negedge clock);
    check("rst_data", 32'(data), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_ferr", 32'(framing_error), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_recv", 32'(receiving), 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    // single good frame, consumer always ready
    v0 = vcount;
    tx_frame(8'h0E);
    repeat (20) @(negedge clock);
    check("t1_valid_cycles", 32'(vcount - v0), 1);
    check("t1_data", 32'(got), 32'h0E);
    check("t1_ferr", 32'(framing_error), 0);
    check("t1_valid_low", 32'(data_valid), 0);
    check("t1_recv", 32'(receiving), 0);
    // short low glitch is rejected at the start-bit check
    v0 = vcount;
    rx = 1'b0;
    repeat (100) @(negedge clock);
    check("t2_recv_high", 32'(receiving), 1);
    rx = 1'b1;
    repeat (CPB) @(negedge clock);
    check("t2_recv_low", 32'(receiving), 0);
    check("t2_no_valid", 32'(vcount - v0), 0);
    check("t2_ferr", 32'(framing_error), 0);
    // stop bit held low for three periods
    v0 = vcount;
    fr = 8'hA5;
    bitp(1'b0);
    for (int i = 0; i < 8; i++) bitp(fr[i]);
    bitp(1'b0);
    bitp(1'b0);
    check("t3_break_recv", 32'(receiving), 1);
    check("t3_ferr", 32'(framing_error), 1);
    bitp(1'b0);
    check("t3_still_break", 32'(receiving), 1);
    rx = 1'b1;
    repeat (10) @(negedge clock);
    check("t3_exit_break", 32'(receiving), 0);
    check("t3_no_valid", 32'(vcount - v0), 0);
    check("t3_ferr_held", 32'(framing_error), 1);
    repeat (CPB) @(negedge clock);
    // back-to-back frames with consumer stalled
    data_ready = 1'b0;
    tx_frame(8'h11);
    tx_frame(8'h22);
    repeat (20) @(negedge clock);
    check("t4_valid", 32'(data_valid), 1);
    check("t4_data_held", 32'(data), 32'h11);
    check("t4_ovr", 32'(overrun), 1);
    check("t4_ferr_cleared", 32'(framing_error), 0);
    data_ready = 1'b1;
    @(negedge clock);
    data_ready = 1'b0;
    @(negedge clock);
    check("t4_valid_after_hs", 32'(data_valid), 0);
    check("t4_ovr_after_hs", 32'(overrun), 0);
    // reset in the middle of a frame, then a fresh frame
    data_ready = 1'b1;
    fr = 8'h3C;
    bitp(1'b0);
    for (int i = 0; i < 4; i++) bitp(fr[i]);
    rx = fr[4];
    repeat (50) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("t5_rst_recv", 32'(receiving), 0);
    check("t5_rst_data", 32'(data), 0);
    check("t5_rst_valid", 32'(data_valid), 0);
    reset = 1'b1;
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    v0 = vcount;
    tx_frame(8'h5A);
    repeat (20) @(negedge clock);
    check("t5_count", 32'(vcount - v0), 1);
    check("t5_data", 32'(got), 32'h5A);
    check("t5_ferr", 32'(framing_error), 0);
    check("t5_ovr", 32'(overrun), 0);
    check("t5_recv", 32'(receiving), 0);
`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so a parity bit of 0 is wrong
    v0 = vcount;
    p0 = pcount;
    fr = 8'h07;
    bitp(1'b0);
    for (int i = 0; i < 8; i++) bitp(fr[i]);
    bitp(1'b0);
    bitp(1'b1);
    repeat (20) @(negedge clock);
    check("t6_perr_pulses", 32'(pcount - p0), 1);
    check("t6_no_valid", 32'(vcount - v0), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
